g_andn_qual: RTL and testbench
==============================

// Module: g_andn_qual
// PURPOSE
//  Parametrised N-input AND macro with per-input polarity mask, an input
//  synchroniser and a persistence (glitch) qualifier. Y changes only after
//  the AND term holds its new value for QUAL_CYC consecutive enabled cycles.
//  YR/YF edge pulses let schematic logic consume transitions directly.
//  Successor to the fixed-width combinational gate macros.
// PARAMETERS
//  N           4        number of inputs, 1..32
//  INV_MASK    4'b0011  bit i=1: input A[i] is active low (inverted)
//  SYNC_STAGES 2        synchroniser flops on A, 0..3 (0 = no sync)
//  QUAL_CYC    4        qualification length in CE cycles, 1..256
// PORTS
//  CK   in   1  clock, rising edge
//  CD   in   1  asynchronous clear, active high
//  CE   in   1  qualification enable; counting advances only when CE=1
//  A    in   N  gate inputs, polarity per INV_MASK
//  Y    out  1  qualified AND output (registered)
//  YR   out  1  one-cycle pulse, coincident with the cycle Y goes 0->1
//  YF   out  1  one-cycle pulse, coincident with the cycle Y goes 1->0
//  CLR  in   1  sticky clear (present only with G_QUAL_STICKY_EN)
// BEHAVIOUR
//  - Reset (CD=1, async): sync flops=0, state=LOW, cnt=0, Y=0, YR=0, YF=0.
//  - Sync: SYNC_STAGES flops on A, always clocked (ignores CE), giving A_s.
//  - Term T = &(A_s ^ INV_MASK), combinational from A_s.
//  - States: LOW (Y=0), RQ (rise-qualify), HIGH (Y=1), FQ (fall-qualify).
//  - LOW: T=1 & CE=1 -> cnt=1. If QUAL_CYC=1, go HIGH. Else go RQ.
//  - RQ: T=0 -> LOW, cnt=0 (any CE). T=1 & CE=1: cnt++.
//    When cnt reaches QUAL_CYC: go HIGH, cnt=0. T=1 & CE=0: hold.
//  - HIGH/FQ: mirror of LOW/RQ with T inverted. Reaching QUAL_CYC -> LOW.
//  - Y is registered from the state. Latency from an A change to Y is
//    SYNC_STAGES + QUAL_CYC cycles, with CE held at 1.
//  - YR=1 for exactly the cycle Y first reads 1; YF likewise for 0. Never both.
//  - Counter width is $clog2(QUAL_CYC+1). It saturates and cannot wrap.
//  - T toggling every cycle with QUAL_CYC>=2: Y never changes.
//  - CE low for any duration mid-qualify: cnt is frozen, not cleared.
//    A T reversal during CE=0 still aborts the qualify.
//  - CD mid-qualify: all state to reset values immediately. No pulse issued.
// CONFIGURATION
//  G_QUAL_STICKY_EN defined:
//    - CLR port exists and Y latches high once qualified; FQ is unreachable.
//    - CLR=1 (sync): HIGH -> LOW with YF pulse, cnt=0. A still-true T then
//      needs a full QUAL_CYC before Y sets again.
//    - CLR=1 in RQ aborts to LOW. CLR beats a same-cycle completion.
//  Not defined: no CLR port; Y falls only via FQ qualification.
// TESTING
//  1 N=4,MASK=0011,SYNC=2,QUAL=4: A=1100 held from cycle 0
//    -> Y=1 and YR=1 at cycle 6; YF stays 0.
//  2 A=1100 for 3 cycles then A=0000 -> Y stays 0, YR/YF never pulse.
//  3 Y=1, then CE=0 for 10 cycles while A=1100 persists
//    -> cnt frozen, Y=1 held; CE back to 1 -> counting resumes from frozen value.
//  4 Y=1, A=0000 held -> Y=0 with YF=1 at 2+4 cycles after the change.
//  5 CD pulse during RQ at cnt=2 -> Y=0, cnt=0 async; requalify takes a full 6.
//  6 STICKY_EN: Y=1, A=0000 for 20 cycles -> Y stays 1.
//    CLR=1 with A=1100 -> YF, then Y re-sets after 4 cycles.
//    CLR and completion in the same cycle -> Y=0.

Source files
------------

// File: rtl/g_andn_qual.sv
// g_andn_qual: N-input AND gate with a per-input polarity mask, an optional
// input synchroniser and a persistence qualifier on the AND term.
// Y moves only after the term has held its new value for QUAL_CYC
// consecutive CE-enabled cycles. YR/YF pulse for the single cycle in which
// Y first shows its new value.
//
// Optional feature macro: G_QUAL_STICKY_EN
//   Defined:   adds the CLR port. Y latches high once qualified and is only
//              released by a synchronous CLR, which wins over everything else.
//   Undefined: no CLR port. Y falls only through fall qualification.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_LOW  | Y=0, term false or not yet seen true on an enabled cycle
// ST_RQ   | Y=0, term true, counting enabled cycles toward a rise
// ST_HIGH | Y=1, term true (or latched when sticky)
// ST_FQ   | Y=1, term false, counting enabled cycles toward a fall

module g_andn_qual #(
  parameter int              N           = 4,
  parameter logic [N-1:0]    INV_MASK    = 4'b0011,
  parameter int              SYNC_STAGES = 2,
  parameter int              QUAL_CYC    = 4
) (
  input  logic         CK,
  input  logic         CD,
  input  logic         CE,
  input  logic [N-1:0] A,
`ifdef G_QUAL_STICKY_EN
  input  logic         CLR,
`endif
  output logic         Y,
  output logic         YR,
  output logic         YF
);

  // Wide enough to hold QUAL_CYC itself, so the count can saturate there.
  localparam int CW = $clog2(QUAL_CYC + 1);
  localparam logic [CW-1:0] QUAL_C = CW'(QUAL_CYC);

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RQ   = 2'd1,
    ST_HIGH = 2'd2,
    ST_FQ   = 2'd3
  } state_t;

  logic [N-1:0]  a_s;
  logic          term;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          y_q, y_d;
  logic          yr_q, yr_d;
  logic          yf_q, yf_d;

  // ---------------------------------------------------------------------
  // Input synchroniser: free-running, deliberately not gated by CE.
  // ---------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign a_s = A;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;

      // Shift A one stage deeper every clock.
      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = A;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchroniser registers, cleared by CD.
      always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign a_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Inverted inputs are active low, so XOR with the mask before the AND.
  assign term = &(a_s ^ INV_MASK);

  // ---------------------------------------------------------------------
  // Qualifier FSM
  // ---------------------------------------------------------------------

  // Next state and count: defaults hold, so CE=0 freezes the counter while
  // a reversal of the term still aborts the qualify.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_LOW: begin
        if (term && CE) begin
          if (QUAL_CYC == 1) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = ST_RQ;
            cnt_d   = CW'(1);
          end
        end
      end

      ST_RQ: begin
        if (!term) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (CE) begin
          if (cnt_q == QUAL_C - 1'b1) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q != QUAL_C) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_HIGH: begin
`ifndef G_QUAL_STICKY_EN
        if (!term && CE) begin
          if (QUAL_CYC == 1) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            state_d = ST_FQ;
            cnt_d   = CW'(1);
          end
        end
`endif
      end

      ST_FQ: begin
        if (term) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (CE) begin
          if (cnt_q == QUAL_C - 1'b1) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q != QUAL_C) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase

`ifdef G_QUAL_STICKY_EN
    // Clear overrides any qualify in progress, including one completing now.
    if (CLR) begin
      state_d = ST_LOW;
      cnt_d   = '0;
    end
`endif
  end

  // Y follows the next state so it appears on the same edge the FSM settles;
  // edge pulses compare that against the current Y.
  always_comb begin
    y_d  = (state_d == ST_HIGH) || (state_d == ST_FQ);
    yr_d = y_d & ~y_q;
    yf_d = ~y_d & y_q;
  end

  // FSM, counter and output registers; CD clears without issuing a pulse.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      yr_q    <= 1'b0;
      yf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yr_q    <= yr_d;
      yf_q    <= yf_d;
    end
  end

  assign Y  = y_q;
  assign YR = yr_q;
  assign YF = yf_q;

endmodule

// File: tb/tb_g_andn_qual.sv
// Testbench for g_andn_qual (N=4, INV_MASK=0011, SYNC_STAGES=2, QUAL_CYC=4).
// A run-length reference model predicts Y/YR/YF for every clock; the
// prediction is queued when inputs are driven and compared after the edge.
// Scenario tasks add fixed-latency checks on top. Build with
// G_QUAL_STICKY_EN defined to exercise the CLR path.

module tb_g_andn_qual;

  localparam int           N     = 4;
  localparam logic [N-1:0] MASK  = 4'b0011;
  localparam int           SYNC  = 2;
  localparam int           QUAL  = 4;
  localparam logic [N-1:0] A_ON  = 4'b1100;
  localparam logic [N-1:0] A_OFF = 4'b0000;

  logic         CK = 1'b0;
  logic         CD = 1'b1;
  logic         CE = 1'b0;
  logic [N-1:0] A  = '0;
  logic         CLR = 1'b0;
  logic         Y, YR, YF;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic y;
    logic yr;
    logic yf;
  } exp_t;

  exp_t          exp_q[$];
  logic [N-1:0]  m_pipe[$];
  logic          m_y;
  int            m_run;

  g_andn_qual #(
    .N(N), .INV_MASK(MASK), .SYNC_STAGES(SYNC), .QUAL_CYC(QUAL)
  ) dut (
    .CK(CK),
    .CD(CD),
    .CE(CE),
    .A(A),
`ifdef G_QUAL_STICKY_EN
    .CLR(CLR),
`endif
    .Y(Y),
    .YR(YR),
    .YF(YF)
  );

  always #5 CK = ~CK;

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
    m_y   = 1'b0;
    m_run = 0;
    exp_q.delete();
  endtask

  // One clock of the reference: count enabled cycles on which the term
  // disagrees with Y; any agreeing cycle restarts the run.
  task automatic model_step(input logic [N-1:0] a, input logic ce, input logic clr);
    logic [N-1:0] src;
    logic t, y_old;
    bit sticky;
    exp_t e;
`ifdef G_QUAL_STICKY_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
    clr = 1'b0;
`endif
    if (SYNC == 0) src = a;
    else begin
      src = m_pipe.pop_front();
      m_pipe.push_back(a);
    end
    t = &(src ^ MASK);
    y_old = m_y;
    if (clr) begin
      m_y = 1'b0;
      m_run = 0;
    end else if (sticky && m_y) begin
      m_run = 0;
    end else if (t == m_y) begin
      m_run = 0;
    end else if (ce) begin
      m_run++;
      if (m_run >= QUAL) begin
        m_y = t;
        m_run = 0;
      end
    end
    e.y  = m_y;
    e.yr = m_y & ~y_old;
    e.yf = ~m_y & y_old;
    exp_q.push_back(e);
  endtask

  // Drive one cycle, clock it, then compare against the queued prediction.
  task automatic tick(input logic [N-1:0] a, input logic ce, input logic clr);
    exp_t e;
    A = a; CE = ce; CLR = clr;
    model_step(a, ce, clr);
    @(posedge CK);
    #1;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty: no expected entry");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({Y, YR, YF} !== {e.y, e.yr, e.yf}) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t: got Y/YR/YF=%b%b%b expected %b%b%b",
                 $time, Y, YR, YF, e.y, e.yr, e.yf);
      end
    end
  endtask

  task automatic do_reset();
    CD = 1'b1; A = A_OFF; CE = 1'b0; CLR = 1'b0;
    model_reset();
    repeat (2) @(posedge CK);
    #1;
    CD = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Y, YR, YF} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b expected 000", Y, YR, YF);
    end
  endtask

  // A=1100 from cycle 0: Y and YR appear at cycle SYNC+QUAL = 6.
  task automatic test_rise();
    for (int k = 1; k <= 8; k++) begin
      tick(A_ON, 1'b1, 1'b0);
      if (k == 5) begin
        checks++;
        if (Y !== 1'b0) begin
          errors++; $display("FAIL rise_early: Y=%b at cycle 5 expected 0", Y);
        end
      end
      if (k == 6) begin
        checks++;
        if ({Y, YR, YF} !== 3'b110) begin
          errors++; $display("FAIL rise_at_6: Y/YR/YF=%b%b%b expected 110", Y, YR, YF);
        end
      end
      if (k == 7) begin
        checks++;
        if ({Y, YR} !== 2'b10) begin
          errors++; $display("FAIL rise_pulse_width: Y/YR=%b%b expected 10", Y, YR);
        end
      end
    end
  endtask

  // Short true pulse from LOW: never qualifies.
  task automatic test_short_pulse();
    int pulses = 0;
    for (int k = 0; k < 3; k++) tick(A_ON, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(A_OFF, 1'b1, 1'b0);
      if (Y !== 1'b0 || YR !== 1'b0 || YF !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL short_pulse: %0d active cycles expected 0", pulses);
    end
  endtask

  // Y=1, then the fall qualify is frozen by CE=0 mid-count and resumes.
  task automatic test_ce_freeze();
    int resumed = 0;
    for (int k = 0; k < 10; k++) tick(A_ON, 1'b0, 1'b0);
    checks++;
    if (Y !== 1'b1) begin
      errors++; $display("FAIL ce_hold_high: Y=%b expected 1", Y);
    end
    for (int k = 0; k < SYNC + 2; k++) tick(A_OFF, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) tick(A_OFF, 1'b0, 1'b0);
    checks++;
    if (Y !== 1'b1) begin
      errors++; $display("FAIL ce_frozen: Y=%b expected 1", Y);
    end
    for (int k = 1; k <= 4 && Y === 1'b1; k++) begin
      tick(A_OFF, 1'b1, 1'b0);
      resumed = k;
    end
    checks++;
    if (resumed != 2 || YF !== 1'b1) begin
      errors++;
      $display("FAIL ce_resume: fell after %0d cycles YF=%b expected 2 and 1", resumed, YF);
    end
  endtask

  // Y=1 then A=0000 held: YF exactly SYNC+QUAL cycles later.
  task automatic test_fall();
    for (int k = 0; k < 8; k++) tick(A_ON, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(A_OFF, 1'b1, 1'b0);
      if (k == 5) begin
        checks++;
        if (Y !== 1'b1) begin
          errors++; $display("FAIL fall_early: Y=%b expected 1", Y);
        end
      end
    end
    checks++;
    if ({Y, YR, YF} !== 3'b001) begin
      errors++; $display("FAIL fall_at_6: Y/YR/YF=%b%b%b expected 001", Y, YR, YF);
    end
  endtask

  // Async clear in RQ at cnt=2, then a full 6-cycle requalify.
  task automatic test_cd_midqualify();
    for (int k = 0; k < SYNC + 2; k++) tick(A_ON, 1'b1, 1'b0);
    #2 CD = 1'b1;
    #1;
    checks++;
    if ({Y, YR, YF} !== 3'b000) begin
      errors++; $display("FAIL cd_async: Y/YR/YF=%b%b%b expected 000", Y, YR, YF);
    end
    model_reset();
    #1 CD = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(A_ON, 1'b1, 1'b0);
      if (k == 5) begin
        checks++;
        if (Y !== 1'b0) begin
          errors++; $display("FAIL cd_requal_early: Y=%b expected 0", Y);
        end
      end
    end
    checks++;
    if ({Y, YR} !== 2'b11) begin
      errors++; $display("FAIL cd_requal_full: Y/YR=%b%b expected 11", Y, YR);
    end
  endtask

  // Term toggling every cycle never moves Y, from either level.
  task automatic test_toggle();
    logic y0;
    int changes = 0;
    y0 = Y;
    for (int k = 0; k < 20; k++) begin
      tick((k % 2) ? A_ON : A_OFF, 1'b1, 1'b0);
      if (Y !== y0) changes++;
    end
    checks++;
    if (changes != 0) begin
      errors++; $display("FAIL toggle: Y changed on %0d cycles expected 0", changes);
    end
  endtask

  // Reversal during CE=0 aborts the rise; model verifies every cycle.
  task automatic test_abort_ce_low();
    for (int k = 0; k < 8; k++) tick(A_OFF, 1'b1, 1'b0);
    for (int k = 0; k < SYNC + 2; k++) tick(A_ON, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) tick(A_ON, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(A_OFF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(A_ON, 1'b1, 1'b0);
    checks++;
    if (Y !== 1'b0) begin
      errors++; $display("FAIL abort_ce_low: Y=%b expected 0", Y);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    int both = 0;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = A_ON;
        2:       a = A_OFF;
        default: a = N'($urandom);
      endcase
      // Long runs of the same value so qualifies actually complete.
      for (int r = 0; r < int'($urandom_range(1, 7)); r++) begin
        tick(a, ($urandom_range(0, 4) != 0), 1'b0);
        if (YR === 1'b1 && YF === 1'b1) both++;
      end
    end
    checks++;
    if (both != 0) begin
      errors++; $display("FAIL yr_yf_both: %0d cycles expected 0", both);
    end
  endtask

`ifdef G_QUAL_STICKY_EN
  task automatic test_sticky();
    do_reset();
    for (int k = 0; k < 6; k++) tick(A_ON, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) tick(A_OFF, 1'b1, 1'b0);
    checks++;
    if (Y !== 1'b1) begin
      errors++; $display("FAIL sticky_hold: Y=%b expected 1", Y);
    end
    for (int k = 0; k < SYNC; k++) tick(A_ON, 1'b1, 1'b0);
    tick(A_ON, 1'b1, 1'b1);
    checks++;
    if ({Y, YF} !== 2'b01) begin
      errors++; $display("FAIL sticky_clr: Y/YF=%b%b expected 01", Y, YF);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(A_ON, 1'b1, 1'b0);
      if (k == 3) begin
        checks++;
        if (Y !== 1'b0) begin
          errors++; $display("FAIL sticky_reset_early: Y=%b expected 0", Y);
        end
      end
    end
    checks++;
    if ({Y, YR} !== 2'b11) begin
      errors++; $display("FAIL sticky_reset_4: Y/YR=%b%b expected 11", Y, YR);
    end
    tick(A_ON, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) tick(A_ON, 1'b1, 1'b0);
    tick(A_ON, 1'b1, 1'b1);
    checks++;
    if (Y !== 1'b0) begin
      errors++; $display("FAIL sticky_clr_beats_done: Y=%b expected 0", Y);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_ce_freeze();
    test_fall();
    test_short_pulse();
    test_cd_midqualify();
    test_toggle();
    test_abort_ce_low();
    test_random();
`ifdef G_QUAL_STICKY_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
